bram_port_arbiter: RTL and testbench



---
 rtl/bram_arb_pkg.sv | 30 +++
 rtl/bram_port_arbiter_rr_arbiter.sv | 86 ++++++++
 rtl/bram_port_arbiter.sv | 113 +++++++++++
 tb/tb_bram_port_arbiter.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/bram_arb_pkg.sv
// Shared types and helpers for the block-RAM port arbiter.
// Upper bounds below cap NUM_REQ at 8 and field widths at 64 bits.
package bram_arb_pkg;

  localparam int unsigned MAX_REQ   = 8;
  localparam int unsigned MAX_ID_W  = 3;
  localparam int unsigned FIELD_MAX = 64;
  localparam int unsigned PACK_W    = MAX_REQ * FIELD_MAX;

  function automatic int unsigned id_width(input int unsigned n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

  typedef struct packed {
    logic                valid;
    logic [MAX_ID_W-1:0] id;
  } pipe_entry_t;

  // Extract field idx of the given width from a packed per-requester bus.
  function automatic logic [FIELD_MAX-1:0] field_slice(
    input logic [PACK_W-1:0] fields,
    input int unsigned       idx,
    input int unsigned       width
  );
    logic [FIELD_MAX-1:0] mask;
    mask = (FIELD_MAX'(1) << width) - FIELD_MAX'(1);
    return FIELD_MAX'(fields >> (idx * width)) & mask;
  endfunction

endpackage

// File: rtl/bram_port_arbiter_rr_arbiter.sv
// Round-robin grant logic with rotating priority pointer.
// Optional lock-owner hold enabled by BRAM_ARB_LOCK_EN.
module rr_arbiter
  import bram_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned ID_W    = id_width(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req_valid,
`ifdef BRAM_ARB_LOCK_EN
  input  logic [NUM_REQ-1:0] req_lock,
`endif
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_idx,
  output logic               advance
);

  logic [ID_W-1:0]    ptr_q;
  logic [ID_W-1:0]    ptr_d;
  logic [ID_W-1:0]    cand;
  logic [ID_W-1:0]    ptr_inc;
  logic [NUM_REQ-1:0] eligible;

  // Scan from the lowest priority up so the last hit is the one nearest ptr_q.
  always_comb begin
    grant_idx = '0;
    advance   = 1'b0;
    cand      = '0;
    for (int unsigned k = NUM_REQ; k > 0; k--) begin
      cand = ID_W'((32'(ptr_q) + k - 1) % NUM_REQ);
      if (eligible[cand]) begin
        grant_idx = cand;
        advance   = 1'b1;
      end
    end
    grant = advance ? (NUM_REQ'(1) << grant_idx) : '0;
  end

  assign ptr_inc = ID_W'((32'(grant_idx) + 1) % NUM_REQ);

`ifdef BRAM_ARB_LOCK_EN
  logic            lock_q;
  logic [ID_W-1:0] owner_q;
  logic            lock_held;

  assign lock_held = lock_q && req_lock[owner_q];

  always_comb begin
    eligible = req_valid;
    if (lock_held) eligible = req_valid & (NUM_REQ'(1) << owner_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_q  <= 1'b0;
      owner_q <= '0;
    end else if (advance && req_lock[grant_idx]) begin
      lock_q  <= 1'b1;
      owner_q <= grant_idx;
    end else if (!lock_held) begin
      lock_q  <= 1'b0;
    end
  end

  // A locked acceptance pins the pointer on the owner instead of moving past it.
  always_comb begin
    ptr_d = ptr_q;
    if (advance) ptr_d = req_lock[grant_idx] ? grant_idx : ptr_inc;
  end
`else
  assign eligible = req_valid;

  always_comb begin
    ptr_d = ptr_q;
    if (advance) ptr_d = ptr_inc;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/bram_port_arbiter.sv
// Shares one block-RAM port between NUM_REQ valid/ready requesters and
// routes read data back after READ_LATENCY. Optional lock: BRAM_ARB_LOCK_EN.
module bram_port_arbiter
  import bram_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ      = 2,
  parameter int unsigned ADDR_W       = 10,
  parameter int unsigned DATA_W       = 18,
  parameter int unsigned READ_LATENCY = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ-1:0]        req_we,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
`ifdef BRAM_ARB_LOCK_EN
  input  logic [NUM_REQ-1:0]        req_lock,
`endif
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      ram_en,
  output logic                      ram_we,
  output logic [ADDR_W-1:0]         ram_addr,
  output logic [DATA_W-1:0]         ram_din,
  output logic                      ram_regce,
  output logic                      ram_rst,
  input  logic [DATA_W-1:0]         ram_dout
);

  localparam int unsigned ID_W  = id_width(NUM_REQ);
  localparam int unsigned DEPTH = READ_LATENCY + 1;

  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    grant_idx;
  logic               advance;
  logic               sel_we;
  logic [ADDR_W-1:0]  sel_addr;
  logic [DATA_W-1:0]  sel_wdata;
  pipe_entry_t        pipe_q [DEPTH];

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
`ifdef BRAM_ARB_LOCK_EN
    .req_lock  (req_lock),
`endif
    .grant     (grant),
    .grant_idx (grant_idx),
    .advance   (advance)
  );

  assign req_ready = grant;

  always_comb begin
    sel_we    = req_we[grant_idx];
    sel_addr  = ADDR_W'(field_slice(PACK_W'(req_addr), 32'(grant_idx), ADDR_W));
    sel_wdata = DATA_W'(field_slice(PACK_W'(req_wdata), 32'(grant_idx), DATA_W));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_en   <= 1'b0;
      ram_we   <= 1'b0;
      ram_addr <= '0;
      ram_din  <= '0;
    end else begin
      ram_en <= advance;
      ram_we <= advance && sel_we;
      if (advance) begin
        ram_addr <= sel_addr;
        ram_din  <= sel_wdata;
      end
    end
  end

  // Stage k is valid in the k-th cycle after the RAM pins carry the read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0].valid <= advance && !sel_we;
      pipe_q[0].id    <= MAX_ID_W'(grant_idx);
      for (int unsigned i = 1; i < DEPTH; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  always_comb begin
    rsp_valid = '0;
    if (pipe_q[READ_LATENCY].valid) rsp_valid = NUM_REQ'(1) << pipe_q[READ_LATENCY].id;
  end

  assign rsp_rdata = ram_dout;

  generate
    if (READ_LATENCY == 2) begin : g_regce
      assign ram_regce = pipe_q[1].valid;
    end else begin : g_no_regce
      assign ram_regce = 1'b0;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ram_rst <= 1'b1;
    else        ram_rst <= 1'b0;
  end

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Scoreboard bench for bram_port_arbiter with a behavioural RAM port model.
// Lock scenario runs only when BRAM_ARB_LOCK_EN is defined.
module tb_bram_port_arbiter;

  localparam int unsigned NUM_REQ = 2;
  localparam int unsigned ADDR_W  = 10;
  localparam int unsigned DATA_W  = 18;
  localparam int unsigned RL      = 2;

  logic                      clk = 1'b0;
  logic                      rst_n = 1'b1;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ-1:0]        req_we;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_wdata;
`ifdef BRAM_ARB_LOCK_EN
  logic [NUM_REQ-1:0]        req_lock;
`endif
  logic [NUM_REQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]         rsp_rdata;
  logic                      ram_en, ram_we, ram_regce, ram_rst;
  logic [ADDR_W-1:0]         ram_addr;
  logic [DATA_W-1:0]         ram_din;
  logic [DATA_W-1:0]         ram_dout;

  always #5 clk = ~clk;

  bram_port_arbiter #(
    .NUM_REQ      (NUM_REQ),
    .ADDR_W       (ADDR_W),
    .DATA_W       (DATA_W),
    .READ_LATENCY (RL)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
`ifdef BRAM_ARB_LOCK_EN
    .req_lock  (req_lock),
`endif
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .ram_en    (ram_en),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_din   (ram_din),
    .ram_regce (ram_regce),
    .ram_rst   (ram_rst),
    .ram_dout  (ram_dout)
  );

  // No-change mode RAM: data latch, then output register gated by regce.
  logic [DATA_W-1:0] mem [1 << ADDR_W];
  logic [DATA_W-1:0] latch_q = '0;
  logic [DATA_W-1:0] dout_q  = '0;

  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_din;
      else        latch_q <= mem[ram_addr];
    end
    if (ram_rst)        dout_q <= '0;
    else if (ram_regce) dout_q <= latch_q;
  end
  assign ram_dout = dout_q;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int                due;
    int                id;
    logic [DATA_W-1:0] data;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: actual 0x%0h required 0x%0h (cycle %0d)", name, act, req, cyc);
  endtask

  task automatic expect_rsp(input int id, input logic [DATA_W-1:0] data);
    q.push_back('{due: cyc + 1 + int'(RL), id: id, data: data});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic [1:0] v, input logic [1:0] we,
                         input logic [ADDR_W-1:0] a0, input logic [ADDR_W-1:0] a1,
                         input logic [DATA_W-1:0] d1);
    req_valid = v;
    req_we    = we;
    req_addr  = {a1, a0};
    req_wdata = {d1, {DATA_W{1'b0}}};
  endtask

  always @(negedge clk) begin
    if (rsp_valid !== '0) begin
      if (q.size() == 0) begin
        check("unexpected_rsp", 64'(rsp_valid), 64'd0);
      end else begin
        e = q.pop_front();
        check("rsp_cycle", 64'(cyc), 64'(e.due));
        check("rsp_valid_id", 64'(rsp_valid), 64'(NUM_REQ'(1) << e.id));
        check("rsp_rdata", 64'(rsp_rdata), 64'(e.data));
      end
    end else if (q.size() > 0 && q[0].due < cyc) begin
      e = q.pop_front();
      check("rsp_missing_at_cycle", 64'(cyc - 1), 64'(e.due));
    end
  end

  initial begin
    for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = '0;
    mem[7] = 18'h2A5;
    set_req(2'b00, 2'b00, '0, '0, '0);
`ifdef BRAM_ARB_LOCK_EN
    req_lock = '0;
`endif
    rst_n = 1'b0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ram_en", 64'(ram_en), 64'd0);
    check("rst_ram_we", 64'(ram_we), 64'd0);
    check("rst_ram_regce", 64'(ram_regce), 64'd0);
    check("rst_ram_addr", 64'(ram_addr), 64'd0);
    check("rst_ram_din", 64'(ram_din), 64'd0);
    check("rst_ram_rst", 64'(ram_rst), 64'd1);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_ready_idle", 64'(req_ready), 64'd0);

    step(); rst_n = 1'b1;
    @(negedge clk); check("ram_rst_hold", 64'(ram_rst), 64'd1);
    step();
    @(negedge clk); check("ram_rst_release", 64'(ram_rst), 64'd0);

    // single read of address 7 by requester 0
    step(); set_req(2'b01, 2'b00, 10'd7, '0, '0);
    @(negedge clk); check("t1_ready", 64'(req_ready), 64'd1); expect_rsp(0, 18'h2A5);
    step(); set_req(2'b00, 2'b00, '0, '0, '0);
    @(negedge clk);
    check("t1_ram_en", 64'(ram_en), 64'd1);
    check("t1_ram_we", 64'(ram_we), 64'd0);
    check("t1_ram_addr", 64'(ram_addr), 64'd7);
    check("t1_regce_t1", 64'(ram_regce), 64'd0);
    step();
    @(negedge clk);
    check("t1_regce_t2", 64'(ram_regce), 64'd1);
    check("t1_idle_en", 64'(ram_en), 64'd0);
    step();
    @(negedge clk); check("t1_regce_t3", 64'(ram_regce), 64'd0);
    step();
    @(negedge clk);
    check("idle_dout_hold", 64'(ram_dout), 64'h2A5);
    check("idle_regce", 64'(ram_regce), 64'd0);
    check("idle_en", 64'(ram_en), 64'd0);

    // requester 1 writes 0x155 to address 3, then reads it back
    step(); set_req(2'b10, 2'b10, '0, 10'd3, 18'h155);
    @(negedge clk); check("t2_wr_ready", 64'(req_ready), 64'd2);
    step(); set_req(2'b10, 2'b00, '0, 10'd3, '0);
    @(negedge clk);
    check("t2_rd_ready", 64'(req_ready), 64'd2);
    check("t2_ram_we", 64'(ram_we), 64'd1);
    check("t2_ram_din", 64'(ram_din), 64'h155);
    check("t2_ram_addr", 64'(ram_addr), 64'd3);
    expect_rsp(1, 18'h155);
    step(); set_req(2'b00, 2'b00, '0, '0, '0);
    @(negedge clk);
    check("t2_rd_en", 64'(ram_en), 64'd1);
    check("t2_rd_we", 64'(ram_we), 64'd0);

    // both requesters continuously valid: strict alternation from P=0
    for (int k = 0; k < 8; k++) begin
      step(); set_req(2'b11, 2'b00, 10'd7, 10'd3, '0);
      @(negedge clk);
      check("fair_ready", 64'(req_ready), (k % 2 == 0) ? 64'd1 : 64'd2);
      expect_rsp(k % 2, (k % 2 == 0) ? 18'h2A5 : 18'h155);
    end
    step(); set_req(2'b00, 2'b00, '0, '0, '0);
    repeat (5) @(negedge clk);

    // reset while a read is in flight: no response, pointer back to 0
    step(); set_req(2'b01, 2'b00, 10'd7, '0, '0);
    @(negedge clk); check("t4_ready", 64'(req_ready), 64'd1);
    step(); set_req(2'b00, 2'b00, '0, '0, '0); rst_n = 1'b0;
    @(negedge clk);
    check("t4_rsp_drop", 64'(rsp_valid), 64'd0);
    check("t4_ram_en", 64'(ram_en), 64'd0);
    check("t4_ram_rst", 64'(ram_rst), 64'd1);
    step(); rst_n = 1'b1;
    @(negedge clk); check("t4_ram_rst_hold", 64'(ram_rst), 64'd1);
    step(); set_req(2'b11, 2'b00, 10'd7, 10'd3, '0);
    @(negedge clk);
    check("t4_ram_rst_release", 64'(ram_rst), 64'd0);
    check("t4_ptr_reset", 64'(req_ready), 64'd1);
    expect_rsp(0, 18'h2A5);
    step(); set_req(2'b00, 2'b00, '0, '0, '0);
    repeat (5) @(negedge clk);

`ifdef BRAM_ARB_LOCK_EN
    // requester 1 locks the port for 4 reads while requester 0 waits
    step(); set_req(2'b10, 2'b00, 10'd7, 10'd3, '0); req_lock = 2'b10;
    @(negedge clk); check("lock_first", 64'(req_ready), 64'd2); expect_rsp(1, 18'h155);
    for (int k = 0; k < 3; k++) begin
      step(); set_req(2'b11, 2'b00, 10'd7, 10'd3, '0); req_lock = 2'b10;
      @(negedge clk); check("lock_held", 64'(req_ready), 64'd2); expect_rsp(1, 18'h155);
    end
    step(); set_req(2'b01, 2'b00, 10'd7, 10'd3, '0); req_lock = 2'b00;
    @(negedge clk); check("lock_released", 64'(req_ready), 64'd1); expect_rsp(0, 18'h2A5);
    step(); set_req(2'b00, 2'b00, '0, '0, '0);
`endif

    for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    check("queue_drained", 64'(q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
